// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: sequences one fully-connected layer: weight/input fetch, MAC strobes, output writes.
// Optional macro FC_CTRL_PERF_CNT_EN adds a 32-bit busy-cycle counter on perf_cycles.
`ifndef OUTNEURON
`define OUTNEURON 4
`endif
`ifndef INNEURON
`define INNEURON 8
`endif
`ifndef PO
`define PO 2
`endif

module fc_layer_ctrl #(
  parameter int unsigned OUTNEURON  = `OUTNEURON,
  parameter int unsigned INNEURON   = `INNEURON,
  parameter int unsigned PO         = `PO,
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned IN_ADDR_W  = 8,
  parameter int unsigned OUT_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  out_ready,
  output logic                  wgt_en,
  output logic                  in_rd_en,
  output logic [IN_ADDR_W-1:0]  in_addr,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  acc_last,
  output logic                  out_we,
  output logic [OUT_ADDR_W-1:0] out_addr,
  output logic                  busy,
`ifdef FC_CTRL_PERF_CNT_EN
  output logic                  done,
  output logic [31:0]           perf_cycles
`else
  output logic                  done
`endif
);

  localparam int unsigned BEATS   = INNEURON / 2;
  localparam int unsigned GROUPS  = OUTNEURON / PO;
  localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [IN_ADDR_W-1:0]  BEAT_LAST  = IN_ADDR_W'(BEATS - 1);
  localparam logic [OUT_ADDR_W-1:0] GROUP_LAST = OUT_ADDR_W'(GROUPS - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One token per RUN beat, travelling alongside the weight-RAM read latency
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } token_t;

  state_t               state;
  state_t               state_n;
  logic [DRAIN_W-1:0]   drain_cnt;
  token_t               tok_in;
  token_t               pipe_q [PIPE_LAT];

  // State register
  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; out_we is the only combinational output
  always_comb begin : next_state
    state_n = state;
    out_we  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (in_addr == BEAT_LAST) state_n = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_n = WRITE;
      end
      WRITE: begin
        out_we = out_ready;
        if (out_ready) begin
          state_n = (out_addr == GROUP_LAST) ? DONE : RUN;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered strobes follow the upcoming state so they align with it
  always_ff @(posedge clk or posedge reset) begin : out_regs
    if (reset) begin
      wgt_en   <= 1'b0;
      in_rd_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      wgt_en   <= (state_n == RUN);
      in_rd_en <= (state_n == RUN);
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
    end
  end

  // Beat counter doubles as the input-pair address
  always_ff @(posedge clk or posedge reset) begin : beat_cnt
    if (reset) begin
      in_addr <= '0;
    end else if (state == RUN) begin
      in_addr <= (in_addr == BEAT_LAST) ? '0 : in_addr + IN_ADDR_W'(1);
    end else begin
      in_addr <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin : drain_counter
    if (reset) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  // Group counter doubles as the output-group address
  always_ff @(posedge clk or posedge reset) begin : group_cnt
    if (reset) begin
      out_addr <= '0;
    end else if (state == IDLE) begin
      out_addr <= '0;
    end else if (state == WRITE && out_ready && out_addr != GROUP_LAST) begin
      out_addr <= out_addr + OUT_ADDR_W'(1);
    end
  end

  always_comb begin : token_src
    tok_in       = '0;
    tok_in.valid = (state == RUN);
    tok_in.first = (state == RUN) && (in_addr == '0);
    tok_in.last  = (state == RUN) && (in_addr == BEAT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin : token_pipe
    if (reset) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tok_in;
      for (int i = 1; i < int'(PIPE_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign acc_en   = pipe_q[PIPE_LAT-1].valid;
  assign acc_clr  = pipe_q[PIPE_LAT-1].first;
  assign acc_last = pipe_q[PIPE_LAT-1].last;

`ifdef FC_CTRL_PERF_CNT_EN
  // Counts busy cycles of the current frame; holds after done
  always_ff @(posedge clk or posedge reset) begin : perf_cnt
    if (reset) begin
      perf_cycles <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb_fc_layer_ctrl: table-driven and randomized frame checks of fc_layer_ctrl against a timeline model.
module tb_fc_layer_ctrl;

  localparam int unsigned OUTN = 4;
  localparam int unsigned INN  = 8;
  localparam int unsigned P    = 2;
  localparam int unsigned LAT  = 3;
  localparam int unsigned IAW  = 8;
  localparam int unsigned OAW  = 8;
  localparam int BEATS  = INN / 2;
  localparam int GROUPS = OUTN / P;
  localparam int TOTAL  = BEATS * GROUPS;
  localparam int MAXC   = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic wgt_en, in_rd_en, acc_clr, acc_en, acc_last, out_we, busy, done;
  logic [IAW-1:0] in_addr;
  logic [OAW-1:0] out_addr;
`ifdef FC_CTRL_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int total = 0;
  int bad = 0;

  bit       rdy     [MAXC];
  bit [7:0] e_flags [MAXC];
  int       e_ia    [MAXC];
  int       e_oa    [MAXC];
  int       addra;

  fc_layer_ctrl #(
    .OUTNEURON(OUTN), .INNEURON(INN), .PO(P), .PIPE_LAT(LAT),
    .IN_ADDR_W(IAW), .OUT_ADDR_W(OAW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
    .wgt_en(wgt_en), .in_rd_en(in_rd_en), .in_addr(in_addr),
    .acc_clr(acc_clr), .acc_en(acc_en), .acc_last(acc_last),
    .out_we(out_we), .out_addr(out_addr), .busy(busy),
`ifdef FC_CTRL_PERF_CNT_EN
    .done(done), .perf_cycles(perf_cycles)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the weight address generator: one address per enabled beat, wrapping per frame
  always @(posedge clk or posedge reset) begin
    if (reset) addra <= 0;
    else if (wgt_en) addra <= (addra + 1) % TOTAL;
  end

  function automatic bit [7:0] flags();
    return {wgt_en, in_rd_en, acc_en, acc_clr, acc_last, out_we, busy, done};
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected timeline of one frame, start accepted in cycle 0, from the out_ready schedule in rdy[]
  task automatic build_model(output int len);
    int c;
    for (int i = 0; i < MAXC; i++) begin
      e_flags[i] = '0; e_ia[i] = 0; e_oa[i] = 0;
    end
    c = 1;
    for (int g = 0; g < GROUPS; g++) begin
      for (int b = 0; b < BEATS; b++) begin
        e_flags[c][7] = 1'b1;
        e_flags[c][6] = 1'b1;
        e_ia[c] = b;
        e_oa[c] = g;
        e_flags[c+LAT][5] = 1'b1;
        if (b == 0) e_flags[c+LAT][4] = 1'b1;
        if (b == BEATS - 1) e_flags[c+LAT][3] = 1'b1;
        c++;
      end
      for (int d = 0; d < LAT; d++) begin
        e_oa[c] = g;
        c++;
      end
      while (!rdy[c]) begin
        e_oa[c] = g;
        c++;
      end
      e_flags[c][2] = 1'b1;
      e_oa[c] = g;
      c++;
    end
    e_flags[c][0] = 1'b1;
    e_oa[c] = GROUPS - 1;
    len = c;
    for (int i = 1; i <= len; i++) e_flags[i][1] = 1'b1;
  endtask

  task automatic run_frame(input bit hold, output int we0, output int we1, output int done_c,
                           output int busy_n, output int oa0, output int oa1);
    int len;
    int nwe;
    build_model(len);
    we0 = -1; we1 = -1; done_c = -1; busy_n = 0; oa0 = -1; oa1 = -1; nwe = 0;
    tick();
    start = 1'b1;
    out_ready = rdy[0];
    #1;
    chk("idle_flags", 0, 32'(flags()), 32'(e_flags[0]));
    for (int c = 1; c <= len; c++) begin
      tick();
      start = hold;
      out_ready = rdy[c];
      #1;
      chk("flags", c, 32'(flags()), 32'(e_flags[c]));
      if (e_flags[c][7]) chk("in_addr", c, 32'(in_addr), e_ia[c]);
      chk("out_addr", c, 32'(out_addr), e_oa[c]);
      if (c == 1) chk("addra_wrap", c, addra, 0);
      if (out_we) begin
        if (nwe == 0) begin we0 = c; oa0 = int'(out_addr); end
        else if (nwe == 1) begin we1 = c; oa1 = int'(out_addr); end
        nwe++;
      end
      if (done) done_c = c;
      if (busy) busy_n++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    string name;
    int    stall_lo;
    int    stall_hi;
    bit    hold;
    int    we0;
    int    we1;
    int    done_c;
    int    busy_n;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int we0, we1, dc, bn, oa0, oa1;
    bit hold;

    tbl[0] = '{"nominal",      0, -1, 1'b0,  8, 16, 17, 17};
    tbl[1] = '{"backpressure", 8, 10, 1'b0, 11, 19, 20, 20};
    tbl[2] = '{"late_stall",  16, 17, 1'b0,  8, 18, 19, 19};
    tbl[3] = '{"start_held",   0, -1, 1'b1,  8, 16, 17, 17};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", 0, 32'(flags()), 32'd0);
    chk("reset_in_addr", 0, 32'(in_addr), 32'd0);
    chk("reset_out_addr", 0, 32'(out_addr), 32'd0);
`ifdef FC_CTRL_PERF_CNT_EN
    chk("reset_perf", 0, perf_cycles, 32'd0);
`endif
    reset = 1'b0;

    foreach (tbl[k]) begin
      for (int c = 0; c < MAXC; c++) rdy[c] = !(c >= tbl[k].stall_lo && c <= tbl[k].stall_hi);
      run_frame(tbl[k].hold, we0, we1, dc, bn, oa0, oa1);
      chk({tbl[k].name, "_we0"}, k, we0, tbl[k].we0);
      chk({tbl[k].name, "_we1"}, k, we1, tbl[k].we1);
      chk({tbl[k].name, "_oa0"}, k, oa0, 0);
      chk({tbl[k].name, "_oa1"}, k, oa1, 1);
      chk({tbl[k].name, "_done"}, k, dc, tbl[k].done_c);
      chk({tbl[k].name, "_busy"}, k, bn, tbl[k].busy_n);
      tick();
      #1;
      chk({tbl[k].name, "_idle_after"}, k, 32'({busy, wgt_en}), 32'd0);
`ifdef FC_CTRL_PERF_CNT_EN
      chk({tbl[k].name, "_perf"}, k, perf_cycles, tbl[k].busy_n);
`endif
    end

    // Reset in cycle 6 of a frame, then a clean nominal frame
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
    tick();
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    #1;
    chk("pre_reset", 6, 32'(flags()), 32'h22);
    reset = 1'b1;
    #1;
    chk("async_reset", 6, 32'(flags()), 32'd0);
    tick();
    #1;
    chk("reset_edge_flags", 7, 32'(flags()), 32'd0);
    chk("reset_edge_addr", 7, 32'({in_addr, out_addr}), 32'd0);
    reset = 1'b0;
    run_frame(1'b0, we0, we1, dc, bn, oa0, oa1);
    chk("post_reset_done", 0, dc, 17);
    chk("post_reset_we1", 0, we1, 16);

    // Back-to-back frames: second start lands on the first IDLE cycle
    run_frame(1'b0, we0, we1, dc, bn, oa0, oa1);
    chk("b2b_done", 0, dc, 17);

    // Randomized out_ready and start-holding, random idle gaps
    for (int f = 0; f < 20; f++) begin
      for (int c = 0; c < MAXC; c++) rdy[c] = (c % 6 == 0) || ($urandom_range(0, 2) != 0);
      hold = 1'($urandom_range(0, 1));
      run_frame(hold, we0, we1, dc, bn, oa0, oa1);
      chk("rand_oa", f, 32'({oa0[7:0], oa1[7:0]}), 32'h0001);
      repeat ($urandom_range(0, 2)) begin
        tick();
        out_ready = 1'($urandom_range(0, 1));
        #1;
        chk("rand_idle", f, 32'(flags()), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_layer_ctrl.md
# fc_layer_ctrl

Sequencer for one fully-connected layer. It drives the `enable` of the FC weight address generator (dual-port, 2 weight words per beat) and the matching input-neuron buffer reads. It tracks the weight-RAM read pipeline and emits accumulator clear, accumulate and last strobes aligned to returning data. It writes each group of PO output neurons with a ready handshake and signals frame completion to the top-level layer scheduler.

## Interface
Parameters:
- `OUTNEURON`, default `OUTNEURON` macro: number of output neurons. Must be a multiple of PO.
- `INNEURON`, default `INNEURON` macro: number of input neurons. Must be even.
- `PO`, default `PO` macro: output neurons computed in parallel per group.
- `PIPE_LAT`, default 3: cycles from `wgt_en` high to the matching weight/input data at the MAC. Must be ≥1.
- `IN_ADDR_W`, default 8: width of `in_addr`. Must be ≥ clog2(INNEURON/2).
- `OUT_ADDR_W`, default 8: width of `out_addr`. Must be ≥ clog2(OUTNEURON/PO).

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: frame start request. Sampled only in IDLE.
- `out_ready`, input, 1: output buffer can accept a write.
- `wgt_en`, output, 1: enable to the weight address generator. One beat = 2 weight words.
- `in_rd_en`, output, 1: input buffer read strobe. Equal to `wgt_en`.
- `in_addr`, output, IN_ADDR_W: input-pair index, 0..INNEURON/2-1.
- `acc_clr`, output, 1: first beat of a group at the MAC.
- `acc_en`, output, 1: valid beat at the MAC.
- `acc_last`, output, 1: last beat of a group at the MAC.
- `out_we`, output, 1: output group write strobe.
- `out_addr`, output, OUT_ADDR_W: output group index, 0..OUTNEURON/PO-1.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle frame-complete pulse.

## Operation
- Derived counts: BEATS = INNEURON/2 per group; GROUPS = OUTNEURON/PO. Per frame, total beats = GROUPS·BEATS. This equals exactly one full wrap of the weight address generator, so that generator needs no separate restart.
- States and transitions:
  - IDLE: go to RUN when `start`=1.
  - RUN: `wgt_en`=`in_rd_en`=1 every cycle. `in_addr` = beat counter. After beat BEATS-1, go to DRAIN.
  - DRAIN: wait PIPE_LAT cycles. Go to WRITE when the last token leaves the pipe.
  - WRITE: `out_we`=`out_ready`. Stay in WRITE while `out_ready`=0. On accept, if the group counter = GROUPS-1 go to DONE, else increment `out_addr` and go to RUN.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Token pipe: a PIPE_LAT-deep shift register carries {valid, first, last}, loaded from the RUN beat. `acc_en`, `acc_clr` and `acc_last` are its output.
- Counters: the beat counter wraps to 0 at BEATS-1. The group counter clears in IDLE.
- `start` in any state other than IDLE is ignored; no queuing.
- Reset values: state=IDLE, all counters 0, token pipe cleared, all outputs 0.
- Reset mid-frame aborts the frame immediately. The weight address generator shares `reset`, so address alignment is preserved.

## Timing
- Cycle n denotes the state held during cycle n. `start`=1 in IDLE at cycle 0 puts the block in RUN at cycle 1.
- Per group: BEATS RUN cycles, then PIPE_LAT DRAIN cycles, then ≥1 WRITE cycle.
- Frame length with `out_ready` always high: GROUPS·(BEATS+PIPE_LAT+1)+1 cycles of `busy`.
- `acc_*` lag `wgt_en` by exactly PIPE_LAT cycles.
- `out_we` is asserted at least one cycle after `acc_last`.
- Outputs are registered except `out_we`, which is combinational from state and `out_ready`.

## Configuration
- `FC_CTRL_PERF_CNT_EN` defined: adds output `perf_cycles` [31:0].
  - Clears on the accepted `start`.
  - Increments every `busy` cycle.
  - Holds after `done` until the next start.
  - Reset value 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Nominal: OUTNEURON=4, INNEURON=8, PO=2, PIPE_LAT=3, `out_ready`=1, `start` at cycle 0.
  - `wgt_en` high cycles 1–4 and 9–12.
  - `acc_en` high cycles 4–7 and 12–15; `acc_clr` at 4 and 12; `acc_last` at 7 and 15.
  - `out_we` at 8 (`out_addr`=0) and 16 (`out_addr`=1).
  - `done` at 17; `busy` high for cycles 1–17.
- Backpressure: same configuration with `out_ready`=0 for cycles 8–10.
  - WRITE is held for 3 cycles; `out_we` fires at 11.
  - Second group RUN spans cycles 12–15; `done` at 20.
- `start` held high during the frame: no second frame starts. A new `start` at IDLE begins a new frame, and `in_addr` restarts at 0.
- Reset at cycle 6 mid-frame: all outputs 0 on the next edge, state IDLE. A subsequent `start` reproduces the nominal waveform.
- Back-to-back frames: two frames run in sequence. The weight address generator `addra` wraps to 0 exactly at the second frame's first beat.
- With `FC_CTRL_PERF_CNT_EN` defined: `perf_cycles`=17 after the nominal frame, and 20 after the backpressure frame.
